// File: rtl/rf_ctrl_pkg.sv
// Shared definitions for the register-file write-port control slice.
package rf_ctrl_pkg;

  localparam int REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] REG_X0 = 5'd0;

  // Arbitration states: normal priority to WB, or a one-cycle forced B grant.
  typedef enum logic {
    ST_NORMAL  = 1'b0,
    ST_FORCE_B = 1'b1
  } arb_state_e;

  // True when the address names a real (writable) register.
  function automatic logic is_real_reg(input logic [REG_ADDR_W-1:0] addr);
    return addr != REG_X0;
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Busy scoreboard for x1..x31: registers with a long-latency write in flight.
// Lookups see registered state only; a simultaneous set and clear of the same
// register keeps it busy because the set belongs to a newer op.
module reg_scoreboard
  import rf_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  set_en,
  input  logic [REG_ADDR_W-1:0] set_addr,
  input  logic                  clr_en,
  input  logic [REG_ADDR_W-1:0] clr_addr,
  input  logic [REG_ADDR_W-1:0] rs1_addr,
  input  logic [REG_ADDR_W-1:0] rs2_addr,
  output logic                  rs1_busy,
  output logic                  rs2_busy,
  output logic                  sb_err
);

  logic [31:1] busy_q;
  logic [31:1] set_mask;
  logic [31:1] clr_mask;
  logic [31:0] busy_vec;
  logic        set_live;
  logic        double_mark;

  // Decode set/clear one-hot masks and detect a mark on an already-busy register.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    set_mask    = '0;
    clr_mask    = '0;
    set_live    = set_en && is_real_reg(set_addr);
    for (int i = 1; i < 32; i++) begin
      set_mask[i] = set_live && (set_addr == REG_ADDR_W'(i));
      clr_mask[i] = clr_en && (clr_addr == REG_ADDR_W'(i));
    end
    // Bit 0 is hardwired idle so x0 lookups always read not-busy.
    busy_vec    = {busy_q, 1'b0};
    double_mark = set_live && busy_vec[set_addr]
                  && !(clr_en && (clr_addr == set_addr));
  end

  assign rs1_busy = busy_vec[rs1_addr];
  assign rs2_busy = busy_vec[rs2_addr];

  // Busy bits: clear then set, so set wins on a same-cycle collision; sb_err is sticky.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
      sb_err <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      busy_q <= (busy_q & ~clr_mask) | set_mask;
      if (double_mark) sb_err <= 1'b1;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Sole owner of the register file write port. WB (port A) has priority and no
// backpressure; the long-latency unit (port B) uses valid/ready. After
// STARVE_LIMIT consecutive blocked B cycles, one cycle is forced to B and WB
// stalls. Grants are combinational so the write lands on the same edge.
module regfile_wb_arbiter
  import rf_ctrl_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  a_wr_en,
  input  logic [REG_ADDR_W-1:0] a_wr_addr,
  input  logic [XLEN-1:0]       a_wr_data,
  output logic                  a_stall,
  input  logic                  b_valid,
  input  logic [REG_ADDR_W-1:0] b_addr,
  input  logic [XLEN-1:0]       b_data,
  output logic                  b_ready,
  input  logic                  mark_en,
  input  logic [REG_ADDR_W-1:0] mark_addr,
  input  logic [REG_ADDR_W-1:0] rs1_addr,
  input  logic [REG_ADDR_W-1:0] rs2_addr,
  output logic                  rs1_busy,
  output logic                  rs2_busy,
  output logic                  sb_err,
  output logic                  rf_regwrite,
  output logic [REG_ADDR_W-1:0] rf_writereg_addr,
  output logic [XLEN-1:0]       rf_writedata
);

  localparam logic [3:0] STARVE_LAST = 4'(STARVE_LIMIT - 1);

  arb_state_e state_q;
  logic [3:0] wait_cnt_q;
  logic       a_live;
  logic       blocked;
  logic       b_xfer;

  // A request to x0 is treated as no request so it never takes the write slot.
  assign a_live  = a_wr_en && is_real_reg(a_wr_addr);
  assign blocked = (state_q == ST_NORMAL) && b_valid && a_live;
  assign b_xfer  = b_valid && b_ready;

  // Grant decode and write-port mux; everything is held quiet while rst is high.
  always_comb begin
    a_stall          = 1'b0;
    b_ready          = 1'b0;
    rf_regwrite      = 1'b0;
    rf_writereg_addr = a_wr_addr;
    rf_writedata     = a_wr_data;
    if (!rst) begin
      if (state_q == ST_FORCE_B || !a_live) begin
        // B owns the port: forced grant, or A has nothing real to write.
        a_stall          = (state_q == ST_FORCE_B);
        b_ready          = 1'b1;
        rf_regwrite      = b_valid && is_real_reg(b_addr);
        rf_writereg_addr = b_addr;
        rf_writedata     = b_data;
      end else begin
        rf_regwrite = 1'b1;
      end
    end
  end

  // Arbitration FSM with starvation counter; FORCE_B lasts exactly one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_NORMAL;
      wait_cnt_q <= '0;
    end else begin
      case (state_q)
        ST_FORCE_B: begin
          state_q    <= ST_NORMAL;
          wait_cnt_q <= '0;
        end
        default: begin
          if (blocked && wait_cnt_q == STARVE_LAST) begin
            state_q    <= ST_FORCE_B;
            wait_cnt_q <= '0;
          end else if (blocked) begin
            wait_cnt_q <= wait_cnt_q + 4'd1;
          end else begin
            wait_cnt_q <= '0;
          end
        end
      endcase
    end
  end

  // Busy tracking for the hazard unit: mark on issue, clear on B transfer.
  reg_scoreboard u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .set_en   (mark_en),
    .set_addr (mark_addr),
    .clr_en   (b_xfer),
    .clr_addr (b_addr),
    .rs1_addr (rs1_addr),
    .rs2_addr (rs2_addr),
    .rs1_busy (rs1_busy),
    .rs2_busy (rs2_busy),
    .sb_err   (sb_err)
  );

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter. Expected register-file writes are
// queued when stimulus is driven and popped whenever the DUT asserts rf_regwrite.
module tb_regfile_wb_arbiter;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_wr_en;
  logic [4:0]  a_wr_addr;
  logic [31:0] a_wr_data;
  logic        a_stall;
  logic        b_valid;
  logic [4:0]  b_addr;
  logic [31:0] b_data;
  logic        b_ready;
  logic        mark_en;
  logic [4:0]  mark_addr;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic        rs1_busy;
  logic        rs2_busy;
  logic        sb_err;
  logic        rf_regwrite;
  logic [4:0]  rf_writereg_addr;
  logic [31:0] rf_writedata;

  int  total = 0;
  int  bad   = 0;
  wr_t exp_q[$];

  regfile_wb_arbiter #(.XLEN(32), .STARVE_LIMIT(4)) dut (
    .clk              (clk),
    .rst              (rst),
    .a_wr_en          (a_wr_en),
    .a_wr_addr        (a_wr_addr),
    .a_wr_data        (a_wr_data),
    .a_stall          (a_stall),
    .b_valid          (b_valid),
    .b_addr           (b_addr),
    .b_data           (b_data),
    .b_ready          (b_ready),
    .mark_en          (mark_en),
    .mark_addr        (mark_addr),
    .rs1_addr         (rs1_addr),
    .rs2_addr         (rs2_addr),
    .rs1_busy         (rs1_busy),
    .rs2_busy         (rs2_busy),
    .sb_err           (sb_err),
    .rf_regwrite      (rf_regwrite),
    .rf_writereg_addr (rf_writereg_addr),
    .rf_writedata     (rf_writedata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic expect_wr(input logic [4:0] addr, input logic [31:0] data);
    wr_t w;
    w.addr = addr;
    w.data = data;
    exp_q.push_back(w);
  endtask

  // Sample on the falling edge; any register-file write is matched against the queue.
  task automatic sample();
    wr_t w;
    @(negedge clk);
    if (rf_regwrite) begin
      if (exp_q.size() == 0) begin
        check("wr_unexpected", {31'd0, rf_regwrite}, 32'd0);
      end else begin
        w = exp_q.pop_front();
        check("wr_addr", {27'd0, rf_writereg_addr}, {27'd0, w.addr});
        check("wr_data", rf_writedata, w.data);
      end
    end
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    a_wr_en = 1'b0; a_wr_addr = '0; a_wr_data = '0;
    b_valid = 1'b0; b_addr = '0; b_data = '0;
    mark_en = 1'b0; mark_addr = '0; rs1_addr = '0; rs2_addr = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // 1. Mid-cycle reset: outputs go quiet immediately and busy bits clear.
    mark_en = 1'b1; mark_addr = 5'd4; rs1_addr = 5'd4;
    advance();
    mark_en = 1'b0;
    sample();
    check("pre_rst_busy", {31'd0, rs1_busy}, 32'd1);
    advance();
    b_valid = 1'b1; b_addr = 5'd6; b_data = 32'h0000_0666;
    #1 rst = 1'b1;
    #1;
    check("rst_b_ready", {31'd0, b_ready}, 32'd0);
    check("rst_regwrite", {31'd0, rf_regwrite}, 32'd0);
    check("rst_rs1_busy", {31'd0, rs1_busy}, 32'd0);
    check("rst_a_stall", {31'd0, a_stall}, 32'd0);
    b_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    sample();
    check("post_rst_sb_err", {31'd0, sb_err}, 32'd0);
    advance();

    // 2. A only; then A to x0 yields the slot to a waiting B.
    a_wr_en = 1'b1; a_wr_addr = 5'd5; a_wr_data = 32'hDEAD_BEEF;
    expect_wr(5'd5, 32'hDEAD_BEEF);
    sample();
    check("a_regwrite", {31'd0, rf_regwrite}, 32'd1);
    check("a_stall", {31'd0, a_stall}, 32'd0);
    advance();
    a_wr_addr = 5'd0;
    sample();
    check("a_x0_regwrite", {31'd0, rf_regwrite}, 32'd0);
    check("a_x0_b_ready", {31'd0, b_ready}, 32'd1);
    advance();
    b_valid = 1'b1; b_addr = 5'd8; b_data = 32'h0000_0088;
    expect_wr(5'd8, 32'h0000_0088);
    sample();
    check("a_x0_b_wins", {31'd0, b_ready}, 32'd1);
    advance();
    b_valid = 1'b0; a_wr_en = 1'b0;

    // 3. B alone is accepted the same cycle.
    b_valid = 1'b1; b_addr = 5'd7; b_data = 32'h0000_1234;
    expect_wr(5'd7, 32'h0000_1234);
    sample();
    check("b_alone_ready", {31'd0, b_ready}, 32'd1);
    check("b_alone_regwrite", {31'd0, rf_regwrite}, 32'd1);
    advance();
    b_valid = 1'b0;

    // 4. Starvation: 4 blocked cycles, forced B on the 5th, A again on the 6th.
    a_wr_en = 1'b1; a_wr_addr = 5'd10; a_wr_data = 32'hAAAA_0001;
    b_valid = 1'b1; b_addr = 5'd12; b_data = 32'hBBBB_0002;
    for (int i = 0; i < 4; i++) begin
      expect_wr(5'd10, 32'hAAAA_0001);
      sample();
      check("starve_b_ready", {31'd0, b_ready}, 32'd0);
      check("starve_a_stall", {31'd0, a_stall}, 32'd0);
      advance();
    end
    expect_wr(5'd12, 32'hBBBB_0002);
    sample();
    check("force_a_stall", {31'd0, a_stall}, 32'd1);
    check("force_b_ready", {31'd0, b_ready}, 32'd1);
    advance();
    b_valid = 1'b0;
    expect_wr(5'd10, 32'hAAAA_0001);
    sample();
    check("after_force_a_stall", {31'd0, a_stall}, 32'd0);
    check("after_force_b_ready", {31'd0, b_ready}, 32'd0);
    advance();
    a_wr_en = 1'b0;

    // 5. Scoreboard set, clear, and same-cycle set-wins.
    mark_en = 1'b1; mark_addr = 5'd9; rs1_addr = 5'd9; rs2_addr = 5'd0;
    sample();
    check("mark_no_bypass", {31'd0, rs1_busy}, 32'd0);
    advance();
    mark_en = 1'b0; rs2_addr = 5'd9;
    sample();
    check("mark_busy_rs1", {31'd0, rs1_busy}, 32'd1);
    check("mark_busy_rs2", {31'd0, rs2_busy}, 32'd1);
    advance();
    b_valid = 1'b1; b_addr = 5'd9; b_data = 32'h0000_0099;
    expect_wr(5'd9, 32'h0000_0099);
    sample();
    check("clr_still_busy", {31'd0, rs1_busy}, 32'd1);
    advance();
    b_valid = 1'b0;
    sample();
    check("clr_done", {31'd0, rs1_busy}, 32'd0);
    advance();
    mark_en = 1'b1; mark_addr = 5'd9;
    advance();
    b_valid = 1'b1; b_addr = 5'd9; b_data = 32'h0000_0999;
    expect_wr(5'd9, 32'h0000_0999);
    sample();
    advance();
    mark_en = 1'b0; b_valid = 1'b0;
    sample();
    check("set_wins_busy", {31'd0, rs1_busy}, 32'd1);
    check("set_wins_no_err", {31'd0, sb_err}, 32'd0);
    advance();

    // 6. Double mark raises sticky sb_err; x0 marks and B to x0 are harmless.
    mark_en = 1'b1; mark_addr = 5'd3; rs1_addr = 5'd3;
    advance();
    sample();
    check("first_mark_no_err", {31'd0, sb_err}, 32'd0);
    advance();
    mark_en = 1'b0;
    sample();
    check("double_mark_err", {31'd0, sb_err}, 32'd1);
    advance();
    mark_en = 1'b1; mark_addr = 5'd0; rs1_addr = 5'd0;
    advance();
    mark_en = 1'b0;
    sample();
    check("x0_not_busy", {31'd0, rs1_busy}, 32'd0);
    check("err_sticky", {31'd0, sb_err}, 32'd1);
    advance();
    b_valid = 1'b1; b_addr = 5'd0; b_data = 32'h5555_5555;
    sample();
    check("b_x0_ready", {31'd0, b_ready}, 32'd1);
    check("b_x0_no_write", {31'd0, rf_regwrite}, 32'd0);
    advance();
    b_valid = 1'b0;
    rst = 1'b1;
    advance();
    rst = 1'b0;
    sample();
    check("err_cleared", {31'd0, sb_err}, 32'd0);

    check("queue_drained", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
